// File: rtl/imem_loader_if.sv
// Byte-stream ingress and instruction-memory write port of the loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a header-prefixed byte stream into 32-bit LE instruction words, holding the CPU meanwhile.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing 8-bit checksum byte after the data words.
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          cpu_hold
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE} state_t;
    localparam state_t S_END = S_CSUM;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;
    localparam state_t S_END = S_DONE;
`endif

    state_t           state, state_nxt;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] word_idx;
    logic [31:0]      hdr;
    logic [23:0]      wbuf;
    logic             err_q;
    logic             ready, accept, start_ok, last_byte, last_word, overflow;
    logic [31:0]      hdr_nxt, word_nxt;
    logic [CNT_W-1:0] n_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign ready = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
`else
    assign ready = (state == S_HDR) || (state == S_DATA);
`endif
    assign accept    = bus.byte_valid && ready;
    assign last_byte = (byte_idx == 2'd3);

    // Both header and data words shift in from the top so the first byte lands in bits [7:0].
    assign hdr_nxt   = {bus.byte_data, hdr[31:8]};
    assign word_nxt  = {bus.byte_data, wbuf};
    assign n_words   = CNT_W'(hdr);
    assign last_word = (word_idx == n_words - CNT_W'(1));
    assign overflow  = (word_idx >= CNT_W'(DEPTH));

    assign bus.byte_ready = ready;
    assign busy           = ready;
    assign cpu_hold       = ready;
    assign done           = (state == S_DONE);
    assign error          = err_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_HDR;
                    start_ok  = 1'b1;
                end
            end
            S_HDR: begin
                if (accept && last_byte)
                    state_nxt = (CNT_W'(hdr_nxt) == '0) ? S_END : S_DATA;
            end
            S_DATA: begin
                if (accept && last_byte && last_word) state_nxt = S_END;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) state_nxt = S_DONE;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx      <= '0;
            word_idx      <= '0;
            hdr           <= '0;
            wbuf          <= '0;
            err_q         <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            bus.mem_we <= 1'b0;
            if (start_ok) begin
                byte_idx <= '0;
                word_idx <= '0;
                hdr      <= '0;
                wbuf     <= '0;
                err_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end else if (accept) begin
                case (state)
                    S_HDR: begin
                        hdr      <= hdr_nxt;
                        byte_idx <= byte_idx + 2'd1;
                    end
                    S_DATA: begin
                        wbuf     <= word_nxt[31:8];
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum + bus.byte_data;
`endif
                        // Out-of-range words are still consumed so the stream stays in step.
                        if (last_byte) begin
                            word_idx <= word_idx + CNT_W'(1);
                            if (overflow) begin
                                err_q <= 1'b1;
                            end else begin
                                bus.mem_we    <= 1'b1;
                                bus.mem_addr  <= 32'(word_idx) << 2;
                                bus.mem_wdata <= word_nxt;
                            end
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (8'(csum + bus.byte_data) != 8'd0) err_q <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    a_addr_aligned: assert property (@(posedge clk) disable iff (rst) bus.mem_addr[1:0] == 2'b00);
    a_done_idle:    assert property (@(posedge clk) disable iff (rst) !(done && busy));
    a_we_session:   assert property (@(posedge clk) disable iff (rst) bus.mem_we |-> state != S_IDLE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (large and tiny DEPTH) share one byte stream,
// and their write traffic and status are compared against a per-session reference model.
module tb_imem_loader;
    localparam int DA = 1024;
    localparam int DB = 2;

    logic clk = 1'b0;
    logic rst, start, valid;
    logic [7:0] data;
    logic busy0, done0, error0, hold0;
    logic busy1, done1, error1, hold1;

    int n_chk = 0;
    int n_fail = 0;

    logic [63:0] obs0[$], obs1[$], exp0[$], exp1[$];
    logic [7:0]  data_q[$];

    imem_loader_if bus0();
    imem_loader_if bus1();

    assign bus0.byte_valid = valid;
    assign bus0.byte_data  = data;
    assign bus1.byte_valid = valid;
    assign bus1.byte_data  = data;

    imem_loader #(.DEPTH(DA), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .start(start), .bus(bus0),
        .busy(busy0), .done(done0), .error(error0), .cpu_hold(hold0)
    );

    imem_loader #(.DEPTH(DB), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst), .start(start), .bus(bus1),
        .busy(busy1), .done(done1), .error(error1), .cpu_hold(hold1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus0.mem_we === 1'b1) obs0.push_back({bus0.mem_addr, bus0.mem_wdata});
        if (bus1.mem_we === 1'b1) obs1.push_back({bus1.mem_addr, bus1.mem_wdata});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_flags0", {busy0, done0, error0, hold0, bus0.byte_ready, bus0.mem_we}, 64'd0);
        chk("rst_addr0",  bus0.mem_addr,  64'd0);
        chk("rst_wdata0", bus0.mem_wdata, 64'd0);
        chk("rst_flags1", {busy1, done1, error1, hold1, bus1.byte_ready, bus1.mem_we}, 64'd0);
        chk("rst_addr1",  bus1.mem_addr,  64'd0);
        chk("rst_wdata1", bus1.mem_wdata, 64'd0);
    endtask

    // Called and returns at a falling edge; the byte is taken on the rising edge in between.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        int k;
        for (int g = 0; g < gap; g++) begin
            valid = 1'b0;
            if (poke && g == 0) start = 1'b1;
            @(posedge clk); @(negedge clk);
            start = 1'b0;
        end
        if (gap > 0) chk("busy_gap", {busy0, hold0, busy1, hold1}, 64'hF);
        valid = 1'b1;
        data  = b;
        k = 0;
        while (bus0.byte_ready !== 1'b1 && k < 20) begin
            @(posedge clk); @(negedge clk);
            k++;
        end
        if (k >= 20) chk("ready_timeout", 64'd0, 64'd1);
        @(posedge clk); @(negedge clk);
        valid = 1'b0;
    endtask

    // One load session over data_q; expected writes come straight from the word/addr rules.
    task automatic run_session(input int gap, input bit with_valid, input bit bad_csum, input bit poke);
        int n;
        logic [7:0]  sum, trl;
        logic [31:0] w;
        bit we0, we1, err0, err1;
        n = data_q.size() / 4;
        obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
        sum = 8'd0;
        for (int k = 0; k < n; k++) begin
            w = {data_q[4*k+3], data_q[4*k+2], data_q[4*k+1], data_q[4*k]};
            if (k < DA) exp0.push_back({32'(k * 4), w});
            if (k < DB) exp1.push_back({32'(k * 4), w});
        end
        foreach (data_q[i]) sum = sum + data_q[i];
        trl = 8'd0 - sum;
        if (bad_csum) trl = trl + 8'd1;

        start = 1'b1;
        if (with_valid) begin
            valid = 1'b1;
            data  = 8'hAA;
        end
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        valid = 1'b0;
        chk("start0", {busy0, done0, error0}, 64'b100);
        chk("start1", {busy1, done1, error1}, 64'b100);

        for (int i = 0; i < 4; i++) send_byte(8'(n >> (8 * i)), 0, 1'b0);
        for (int i = 0; i < data_q.size(); i++) send_byte(data_q[i], gap, poke && i == 2);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(trl, gap, 1'b0);
        we0  = 1'b0;
        we1  = 1'b0;
        err0 = (n > DA) || bad_csum;
        err1 = (n > DB) || bad_csum;
`else
        we0  = (n > 0) && (n <= DA);
        we1  = (n > 0) && (n <= DB);
        err0 = (n > DA);
        err1 = (n > DB);
`endif
        chk("end0", {done0, busy0, hold0, error0, bus0.mem_we}, {59'd0, 1'b1, 1'b0, 1'b0, err0, we0});
        chk("end1", {done1, busy1, hold1, error1, bus1.mem_we}, {59'd0, 1'b1, 1'b0, 1'b0, err1, we1});

        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("sticky0", {done0, busy0, error0}, {61'd0, 1'b1, 1'b0, err0});
        chk("sticky1", {done1, busy1, error1}, {61'd0, 1'b1, 1'b0, err1});
        chk("nwr0", 64'(obs0.size()), 64'(exp0.size()));
        chk("nwr1", 64'(obs1.size()), 64'(exp1.size()));
        for (int i = 0; i < obs0.size() && i < exp0.size(); i++) chk("wr0", obs0[i], exp0[i]);
        for (int i = 0; i < obs1.size() && i < exp1.size(); i++) chk("wr1", obs1[i], exp1[i]);
    endtask

    task automatic fill_random(input int n);
        data_q.delete();
        for (int i = 0; i < 4 * n; i++) data_q.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; data = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state();
        rst = 1'b0;
        // Bytes offered in IDLE are neither accepted nor move anything.
        valid = 1'b1; data = 8'h55;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        valid = 1'b0;
        chk_reset_state();

        // Known two-word program, start coinciding with byte_valid.
        data_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_session(0, 1'b1, 1'b0, 1'b0);

        // Empty program.
        data_q.delete();
        run_session(0, 1'b0, 1'b0, 1'b0);

        // Three words: overflows the DEPTH=2 instance only.
        fill_random(3);
        run_session(0, 1'b0, 1'b0, 1'b0);

        // One word with stalls, plus a start pulse mid-session that must be ignored.
        fill_random(1);
        run_session(5, 1'b0, 1'b0, 1'b1);

        // Reset part-way through the second word.
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        send_byte(8'd2, 0, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'd0, 0, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)), 0, 1'b0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_reset_state();
        rst = 1'b0;
        obs0.delete(); obs1.delete();
        valid = 1'b1; data = 8'hC3;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        valid = 1'b0;
        chk("post_rst_nowr", 64'(obs0.size() + obs1.size()), 64'd0);
        fill_random(2);
        run_session(0, 1'b0, 1'b0, 1'b0);

        // Checksum vectors (trailer only exists when the checksum build is enabled).
        data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_session(0, 1'b0, 1'b0, 1'b0);
        run_session(0, 1'b0, 1'b1, 1'b0);

        for (int s = 0; s < 10; s++) begin
            fill_random($urandom_range(0, 4));
            run_session($urandom_range(0, 2), 1'(s % 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
